// File: rtl/fifo_rd_stream_if.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_if
// Bundles the two buses of the FIFO read-side adapter:
//   - FIFO read port : empty (FIFO -> adapter), rdreq (adapter -> FIFO),
//                      q (FIFO -> adapter, valid a fixed latency after rdreq)
//   - Output stream  : data/valid (adapter -> consumer), ready (consumer ->
//                      adapter), level (words held in the adapter buffer)
// Modports:
//   master : the adapter (fifo_rd_stream) side
//   slave  : the environment side (FIFO plus consumer)
// ----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
    parameter int DWIDTH     = 8,
    parameter int OBUF_DEPTH = 4
);
    localparam int LW = $clog2(OBUF_DEPTH) + 1;

    logic              empty;
    logic              rdreq;
    logic [DWIDTH-1:0] q;
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic [LW-1:0]     level;

    modport master (
        input  empty, q, ready,
        output rdreq, data, valid, level
    );

    modport slave (
        output empty, q, ready,
        input  rdreq, data, valid, level
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side adapter sitting directly behind a FIFO. It turns the FIFO's
// rdreq/q port (fixed read latency RD_LATENCY) into a valid/ready stream.
// Reads are issued autonomously while the FIFO has data and the output
// buffer is guaranteed to have room for every word already in flight, so
// consumer backpressure can never drop a word.
//
// Parameters:
//   DWIDTH      data word width
//   RD_LATENCY  cycles from rdreq to valid q (1..8)
//   OBUF_DEPTH  output buffer entries (power of 2, >= 2)
//
// Ports:
//   clk_i      single clock, all logic on posedge
//   srst_n_i   synchronous reset, active-low
//   flush_i    drops buffered and in-flight words (abort path only)
//   bus        fifo_rd_stream_if.master: empty/rdreq/q toward the FIFO,
//              data/valid/ready/level toward the consumer
//   beats_o    (FIFO_RD_STREAM_STATS_EN only) saturating transfer count
//   stalls_o   (FIFO_RD_STREAM_STATS_EN only) saturating valid&&!ready count
//
// Configuration macro: FIFO_RD_STREAM_STATS_EN adds the statistics counters.
// ----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DWIDTH     = 8,
    parameter int RD_LATENCY = 1,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  srst_n_i,
    input  logic                  flush_i,
    fifo_rd_stream_if.master      bus
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           beats_o,
    output logic [31:0]           stalls_o
`endif
);
    localparam int PW = $clog2(OBUF_DEPTH);
    localparam int LW = PW + 1;
    // Wide enough for level plus up to 8 outstanding reads.
    localparam int CW = LW + 4;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [RD_LATENCY-1:0] infl_q, infl_d;
    logic [DWIDTH-1:0]     mem_q [OBUF_DEPTH];

    logic [CW-1:0]         outstanding;
    logic                  rdreq;
    logic                  valid;
    logic                  push;
    logic                  pop;

    // Read issue: words already buffered plus reads still in flight must
    // leave room for one more. A pop in the same cycle is deliberately not
    // credited, which keeps overflow impossible without a pop->rdreq path.
    always_comb begin
        outstanding = CW'(level_q);
        for (int k = 0; k < RD_LATENCY; k++) begin
            outstanding = outstanding + CW'(infl_q[k]);
        end
        rdreq = srst_n_i && !bus.empty && !flush_i
                && (outstanding < CW'(OBUF_DEPTH));
        valid = (level_q != '0);
        // A flush discards the word landing this cycle and blocks any pop.
        push  = infl_q[RD_LATENCY-1] && !flush_i;
        pop   = valid && bus.ready && !flush_i;
    end

    // Next-state: in-flight shift register, pointers and level. A flush
    // empties the buffer by snapping rd_ptr onto wr_ptr.
    always_comb begin
        infl_d    = '0;
        infl_d[0] = rdreq;
        for (int k = 1; k < RD_LATENCY; k++) begin
            infl_d[k] = infl_q[k-1];
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        if (flush_i) begin
            infl_d   = '0;
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end
    end

    // State registers. The overflow check guards the read-issue rule.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            infl_q   <= '0;
        end else begin
            assert (!(push && !pop && (level_q == LW'(OBUF_DEPTH))));
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            infl_q   <= infl_d;
        end
    end

    // Buffer storage has no reset; entries are only read once level covers them.
    always_ff @(posedge clk_i) begin
        if (srst_n_i && push) begin
            mem_q[wr_ptr_q] <= bus.q;
        end
    end

    assign bus.rdreq = rdreq;
    assign bus.valid = valid;
    assign bus.data  = mem_q[rd_ptr_q];
    assign bus.level = level_q;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] beats_q, beats_d;
    logic [31:0] stalls_q, stalls_d;

    // Saturating counters; flush does not clear them, only reset does.
    always_comb begin
        beats_d  = beats_q;
        stalls_d = stalls_q;
        if (valid && bus.ready && (beats_q != 32'hFFFF_FFFF)) begin
            beats_d = beats_q + 32'd1;
        end
        if (valid && !bus.ready && (stalls_q != 32'hFFFF_FFFF)) begin
            stalls_d = stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            beats_q  <= beats_d;
            stalls_q <= stalls_d;
        end
    end

    assign beats_o  = beats_q;
    assign stalls_o = stalls_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Two adapters: dut0 (RD_LATENCY=1, OBUF_DEPTH=4) for reset, streaming,
// backpressure, empty-edge and statistics; dut1 (RD_LATENCY=3, OBUF_DEPTH=4)
// for flush. Each has a FIFO model behind it and a scoreboard queue in front.
// ----------------------------------------------------------------------------
module tb_fifo_rd_stream;
    logic clk = 1'b0;
    logic srst_n0, srst_n1;
    logic flush0, flush1;

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_rd_stream_if #(.DWIDTH(8), .OBUF_DEPTH(4)) bus0 ();
    fifo_rd_stream_if #(.DWIDTH(8), .OBUF_DEPTH(4)) bus1 ();

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] beats0, stalls0, beats1, stalls1;
`endif

    fifo_rd_stream #(.DWIDTH(8), .RD_LATENCY(1), .OBUF_DEPTH(4)) dut0 (
        .clk_i    (clk),
        .srst_n_i (srst_n0),
        .flush_i  (flush0),
        .bus      (bus0)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .beats_o  (beats0),
        .stalls_o (stalls0)
`endif
    );

    fifo_rd_stream #(.DWIDTH(8), .RD_LATENCY(3), .OBUF_DEPTH(4)) dut1 (
        .clk_i    (clk),
        .srst_n_i (srst_n1),
        .flush_i  (flush1),
        .bus      (bus1)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .beats_o  (beats1),
        .stalls_o (stalls1)
`endif
    );

    always #5 clk = ~clk;

    // FIFO models: push side written by the stimulus, pop side by the clock.
    logic [7:0] fmem0 [256];
    logic [7:0] fmem1 [256];
    int push_cnt0 = 0, pop_cnt0 = 0;
    int push_cnt1 = 0, pop_cnt1 = 0;
    logic [7:0] pipe1 [3];

    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    assign bus0.empty = (push_cnt0 == pop_cnt0);
    assign bus1.empty = (push_cnt1 == pop_cnt1);
    assign bus1.q     = pipe1[2];

    // Latency-1 FIFO: the word appears on q the cycle after rdreq.
    always @(posedge clk) begin
        if (bus0.rdreq) begin
            bus0.q   <= fmem0[pop_cnt0 % 256];
            pop_cnt0 <= pop_cnt0 + 1;
        end
    end

    // Latency-3 FIFO: three-stage pipe behind the read.
    always @(posedge clk) begin
        if (bus1.rdreq) begin
            pipe1[0] <= fmem1[pop_cnt1 % 256];
            pop_cnt1 <= pop_cnt1 + 1;
        end else begin
            pipe1[0] <= 8'h00;
        end
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Loads one word into a FIFO model; expect_out adds it to the scoreboard.
    task automatic applyStimulus(input int inst, input logic [7:0] word,
                                 input bit expect_out);
        if (inst == 0) begin
            fmem0[push_cnt0 % 256] = word;
            push_cnt0++;
            if (expect_out) exp0.push_back(word);
        end else begin
            fmem1[push_cnt1 % 256] = word;
            push_cnt1++;
            if (expect_out) exp1.push_back(word);
        end
    endtask

    // Scoreboard monitors: every transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (srst_n0 && bus0.valid && bus0.ready) begin
            checkOutput("sb0_pending", 32'(exp0.size() > 0), 32'd1);
            if (exp0.size() > 0) checkOutput("sb0_data", 32'(bus0.data), 32'(exp0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (srst_n1 && bus1.valid && bus1.ready) begin
            checkOutput("sb1_pending", 32'(exp1.size() > 0), 32'd1);
            if (exp1.size() > 0) checkOutput("sb1_data", 32'(bus1.data), 32'(exp1.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Waits (bounded) until dut0 has delivered everything and gone idle.
    task automatic waitDrain0(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp0.size() == 0 && !bus0.valid) break;
        end
        checkOutput(tag, 32'(exp0.size()), 32'd0);
    endtask

    initial begin
        int pulses;
        int xfers;
        int seen;
        srst_n0    = 1'b0;
        srst_n1    = 1'b0;
        flush0     = 1'b0;
        flush1     = 1'b0;
        bus0.ready = 1'b1;
        bus1.ready = 1'b0;

        // Reset with data available and ready high: nothing may move.
        for (int i = 1; i <= 16; i++) applyStimulus(0, 8'(i), 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_rdreq", 32'(bus0.rdreq), 32'd0);
            checkOutput("rst_valid", 32'(bus0.valid), 32'd0);
            checkOutput("rst_level", 32'(bus0.level), 32'd0);
        end

        // Streaming: first valid two cycles after release, then 16 in a row.
        @(posedge clk); #1 srst_n0 = 1'b1;
        @(negedge clk);
        checkOutput("stream_rdreq_first", 32'(bus0.rdreq), 32'd1);
        checkOutput("stream_valid_c0", 32'(bus0.valid), 32'd0);
        @(negedge clk);
        checkOutput("stream_valid_c1", 32'(bus0.valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("stream_valid_run", 32'(bus0.valid), 32'd1);
        end
        @(negedge clk);
        checkOutput("stream_valid_end", 32'(bus0.valid), 32'd0);
        checkOutput("stream_drained", 32'(exp0.size()), 32'd0);

        // Backpressure: 10 words, ready low -> exactly 4 reads, buffer full.
        @(posedge clk); #1 bus0.ready = 1'b0;
        for (int i = 1; i <= 10; i++) applyStimulus(0, 8'(i), 1'b1);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus0.rdreq) pulses++;
        end
        checkOutput("bp_pulses", 32'(pulses), 32'd4);
        checkOutput("bp_level", 32'(bus0.level), 32'd4);
        checkOutput("bp_valid", 32'(bus0.valid), 32'd1);
        checkOutput("bp_data", 32'(bus0.data), 32'h01);
        repeat (3) @(negedge clk);
        checkOutput("bp_data_hold", 32'(bus0.data), 32'h01);
        checkOutput("bp_rdreq_full", 32'(bus0.rdreq), 32'd0);
        @(posedge clk); #1 bus0.ready = 1'b1;
        waitDrain0("bp_drain");

        // Empty edge: a single word gives one read and one transfer.
        @(posedge clk); #1 applyStimulus(0, 8'hA5, 1'b1);
        pulses = 0;
        xfers  = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus0.rdreq) pulses++;
            if (bus0.valid && bus0.ready) xfers++;
        end
        checkOutput("edge_pulses", 32'(pulses), 32'd1);
        checkOutput("edge_xfers", 32'(xfers), 32'd1);
        checkOutput("edge_valid", 32'(bus0.valid), 32'd0);
        checkOutput("edge_rdreq", 32'(bus0.rdreq), 32'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
        // Statistics: 5 stall cycles then 8 transfers.
        @(posedge clk); #1 srst_n0 = 1'b0; bus0.ready = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'(8'h40 + i), 1'b1);
        #1 srst_n0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus0.valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("stats_valid_seen", 32'(seen), 32'd1);
        repeat (5) @(posedge clk);
        #1 bus0.ready = 1'b1;
        waitDrain0("stats_drain");
        checkOutput("stats_beats", beats0, 32'd8);
        checkOutput("stats_stalls", stalls0, 32'd5);
`endif

        // Flush on dut1: wait for 2 buffered (2 more in flight), then flush.
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'hC0 + i), 1'b0);
        @(posedge clk); #1 srst_n1 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.level == 3'd2) begin
                seen = 1;
                break;
            end
        end
        checkOutput("fl_level_pre", 32'(bus1.level), 32'd2);
        flush1 = 1'b1;
        @(posedge clk); #1 flush1 = 1'b0; bus1.ready = 1'b1;
        @(negedge clk);
        checkOutput("fl_level_post", 32'(bus1.level), 32'd0);
        checkOutput("fl_valid_post", 32'(bus1.valid), 32'd0);
        xfers = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus1.valid) xfers++;
        end
        checkOutput("fl_no_leak", 32'(xfers), 32'd0);
        checkOutput("fl_level_end", 32'(bus1.level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
